fp_normalizer: RTL and testbench

- Pipelined post-operation normalizer for the FPU datapath; the left-shift counterpart of the right-shifting alignment barrel shifter.
- Takes an unnormalized significand and its biased exponent, and counts leading zeros.
- Left-shifts until bit MANT_W-1 is set and decrements the exponent to match, flagging zero and underflow (denormal) results.
- Two register stages with valid/ready handshakes on input and output; one transaction per cycle throughput.

---
 rtl/fp_normalizer.sv | 133 +++++++++++++
 tb/tb_fp_normalizer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Two-stage pipelined FPU post-normalizer: leading-zero count, left shift, exponent adjust.
// Optional perf counters are enabled with `define FP_NORM_PERF_CNT_EN.
module fp_normalizer #(
  parameter int MANT_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_underflow
`ifdef FP_NORM_PERF_CNT_EN
  ,
  output logic [15:0]       perf_cnt,
  output logic [15:0]       perf_uf_cnt
`endif
);

  localparam int SHAMT_W = $clog2(MANT_W);
  // compare width large enough for both the exponent and the leading-zero count
  localparam int CW = ((EXP_W > SHAMT_W) ? EXP_W : SHAMT_W) + 1;

  logic               s1_valid;
  logic [MANT_W-1:0]  s1_mant;
  logic [EXP_W-1:0]   s1_exp;
  logic [SHAMT_W-1:0] s1_lzc;
  logic               s1_zero;

  logic               s1_adv;
  logic               s2_adv;
  logic [SHAMT_W-1:0] lzc;
  logic               found;

  logic [CW-1:0]      lzc_ext;
  logic [CW-1:0]      exp_ext;
  logic [MANT_W-1:0]  nxt_mant;
  logic [EXP_W-1:0]   nxt_exp;
  logic               nxt_zero;
  logic               nxt_uf;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;

  // priority scan from the MSB; result is don't-care for a zero significand
  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found && in_mant[i]) begin
        lzc   = SHAMT_W'(MANT_W - 1 - i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_mant  <= in_mant;
      s1_exp   <= in_exp;
      s1_lzc   <= lzc;
      s1_zero  <= (in_mant == '0);
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  assign lzc_ext = CW'(s1_lzc);
  assign exp_ext = CW'(s1_exp);

  // when the exponent cannot absorb the full shift, stop at exp and go denormal
  always_comb begin
    nxt_mant = '0;
    nxt_exp  = '0;
    nxt_zero = 1'b0;
    nxt_uf   = 1'b0;
    if (s1_zero) begin
      nxt_zero = 1'b1;
    end else if (lzc_ext < exp_ext) begin
      nxt_mant = s1_mant << s1_lzc;
      nxt_exp  = EXP_W'(exp_ext - lzc_ext);
    end else begin
      nxt_mant = s1_mant << s1_exp;
      nxt_uf   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_mant      <= '0;
      out_exp       <= '0;
      out_zero      <= 1'b0;
      out_underflow <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mant      <= nxt_mant;
        out_exp       <= nxt_exp;
        out_zero      <= nxt_zero;
        out_underflow <= nxt_uf;
      end
    end
  end

`ifdef FP_NORM_PERF_CNT_EN
  // saturating counters of completed output transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt    <= '0;
      perf_uf_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 16'd1;
      if (out_underflow && (perf_uf_cnt != 16'hFFFF)) perf_uf_cnt <= perf_uf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: table vectors, backpressure, random streaming and
// mid-operation reset, with a scoreboard fed by an arithmetic reference model.
module tb_fp_normalizer;

  localparam int MW = 32;
  localparam int EW = 8;

  typedef struct packed {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          zero;
    logic          uf;
  } res_t;

  typedef struct {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    res_t          want;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] in_mant = '0;
  logic [EW-1:0] in_exp = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_zero;
  logic          out_underflow;
`ifdef FP_NORM_PERF_CNT_EN
  logic [15:0]   perf_cnt;
  logic [15:0]   perf_uf_cnt;
`endif

  int   compared = 0;
  int   mismatched = 0;
  res_t sb[$];
  res_t got;
  res_t head;
  res_t held;
  vec_t vecs[8];

  fp_normalizer #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .out_underflow(out_underflow)
`ifdef FP_NORM_PERF_CNT_EN
    , .perf_cnt(perf_cnt), .perf_uf_cnt(perf_uf_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // doubling until the top bit is set gives the leading-zero count
  function automatic res_t model(logic [MW-1:0] m, logic [EW-1:0] e);
    res_t   r;
    longint v;
    int     lz;
    r = '0;
    if (m == 0) begin
      r.zero = 1'b1;
      return r;
    end
    v  = longint'(m);
    lz = 0;
    while (v < 64'h8000_0000) begin
      v  = v * 2;
      lz = lz + 1;
    end
    if (lz < int'(e)) begin
      r.mant = MW'(v);
      r.exp  = EW'(int'(e) - lz);
    end else begin
      r.mant = MW'(longint'(m) * (64'd1 << e));
      r.uf   = 1'b1;
    end
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got = {out_mant, out_exp, out_zero, out_underflow};
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_out: got %h want no output at %0t", got, $time);
        end else begin
          head = sb.pop_front();
          check("sb_out", 64'(got), 64'(head));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_mant, in_exp));
    end
  end

  task automatic applyStimulus(input logic [MW-1:0] m, input logic [EW-1:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic checkOutput(string name, res_t want);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check(name, 64'({out_mant, out_exp, out_zero, out_underflow}), 64'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h0000_1234, 8'd100, '{32'h91A0_0000, 8'd81,  1'b0, 1'b0}};
    vecs[1] = '{32'h8000_0001, 8'd127, '{32'h8000_0001, 8'd127, 1'b0, 1'b0}};
    vecs[2] = '{32'h0000_00FF, 8'd10,  '{32'h0003_FC00, 8'd0,   1'b0, 1'b1}};
    vecs[3] = '{32'h0000_8000, 8'd16,  '{32'h8000_0000, 8'd0,   1'b0, 1'b1}};
    vecs[4] = '{32'h0000_0000, 8'd50,  '{32'h0000_0000, 8'd0,   1'b1, 1'b0}};
    vecs[5] = '{32'h0000_0001, 8'd200, '{32'h8000_0000, 8'd169, 1'b0, 1'b0}};
    vecs[6] = '{32'h0000_0001, 8'd31,  '{32'h8000_0000, 8'd0,   1'b0, 1'b1}};
    vecs[7] = '{32'hFFFF_FFFF, 8'd0,   '{32'hFFFF_FFFF, 8'd0,   1'b0, 1'b1}};

    #2;
    check("reset_outputs", 64'({out_valid, out_mant, out_exp, out_zero, out_underflow}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].mant, vecs[i].exp);
      checkOutput($sformatf("vec%0d", i), vecs[i].want);
    end
    waitDrain("drain_table");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mant   = 32'h0000_0F00;
    in_exp    = 8'd40;
    held      = model(32'h0000_0F00, 8'd40);
    @(posedge clk);
    #1 in_mant = 32'h0000_0003;
    in_exp = 8'd3;
    @(posedge clk);
    #1 in_mant = 32'h0012_3456;
    in_exp = 8'd90;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold", 64'({out_valid, out_mant, out_exp, out_zero, out_underflow}),
            64'({1'b1, held}));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_out_a", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_out_b", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("bp_out_c", 64'(out_valid), 64'd1);
    waitDrain("drain_bp");

    $display("[TB] random streaming");
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_mant  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) in_mant = '0;
      in_exp = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 40)) : EW'($urandom_range(0, 255));
      @(negedge clk);
      if (i >= 2) check("stream_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    waitDrain("drain_stream");

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(32'h0000_0777, 8'd60);
    applyStimulus(32'h0100_0000, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", 64'({out_valid, out_mant, out_exp, out_zero, out_underflow}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(32'h4000_0000, 8'd5);
    checkOutput("post_reset", '{32'h8000_0000, 8'd4, 1'b0, 1'b0});
`ifdef FP_NORM_PERF_CNT_EN
    @(negedge clk);
    check("perf_cnt", 64'(perf_cnt), 64'd1);
    check("perf_uf_cnt", 64'(perf_uf_cnt), 64'd0);
`endif
    waitDrain("drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
